// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, frame width and default baud divisor shared by the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int UART_DATA_BITS = 8;

  localparam int SYS_CLK_HZ           = 27_000_000;
  localparam int BAUD_RATE            = 115_200;
  localparam int DEFAULT_CLKS_PER_BIT = SYS_CLK_HZ / BAUD_RATE;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: SYNC_STAGES-deep synchroniser for the asynchronous RX pin plus a falling-edge detector.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // The line idles high, so the flops reset to 1 to avoid a false start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '1;
      prev  <= 1'b1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], rx};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign rx_s = chain[SYNC_STAGES-1];
  assign fall = prev & ~rx_s;

endmodule

// File: rtl/uart_rx_byte_source.sv
// uart_rx_byte_source: oversampling 8N1 receiver that holds the last good byte for the Wishbone RX slave.
// Defining UART_RX_PARITY_EN switches the frame to 8E1 and adds the parity_err_o output.
module uart_rx_byte_source
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      rx_i,
  input  logic                      ack_i,
  output logic [UART_DATA_BITS-1:0] data_o,
  output logic                      valid_o,
  output logic                      overrun_o,
  output logic                      frame_err_o,
  output logic                      busy_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic                      parity_err_o
`endif
);

  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_IDX  = 3'(UART_DATA_BITS - 1);

  rx_state_t                 state;
  rx_state_t                 state_nxt;
  logic [15:0]               cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      rx_s;
  logic                      fall;
  logic                      half_hit;
  logic                      bit_hit;
  logic                      stop_sample;
  logic                      parity_ok;
  logic                      good_frame;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk_i),
    .rst (rst_i),
    .rx  (rx_i),
    .rx_s(rx_s),
    .fall(fall)
  );

  assign half_hit    = (cnt == HALF_LAST);
  assign bit_hit     = (cnt == BIT_LAST);
  assign stop_sample = (state == STOP) && bit_hit;
  assign busy_o      = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign parity_ok = ~^{shreg, par_bit};
`else
  assign parity_ok = 1'b1;
`endif

  assign good_frame = stop_sample && rx_s && parity_ok;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fall) state_nxt = START;
      end
      START: begin
        if (half_hit) state_nxt = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (bit_hit && (bit_idx == LAST_IDX)) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_hit) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (bit_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The baud counter restarts on every state change and wraps once per bit period.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if ((state_nxt != state) || bit_hit) begin
        cnt <= '0;
      end else if (state != IDLE) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_idx <= '0;
      shreg   <= '0;
    end else if (state == START) begin
      bit_idx <= '0;
    end else if ((state == DATA) && bit_hit) begin
      shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
      bit_idx <= bit_idx + 3'd1;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_bit      <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      if ((state == PARITY) && bit_hit) par_bit <= rx_s;
      parity_err_o <= stop_sample && !parity_ok;
    end
  end
`endif

  // A load in the same cycle as ack_i wins: the new byte stays valid and no overrun is flagged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o      <= '0;
      valid_o     <= 1'b0;
      overrun_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= stop_sample && !rx_s;
      if (good_frame) begin
        data_o    <= shreg;
        valid_o   <= 1'b1;
        overrun_o <= ack_i ? 1'b0 : (overrun_o | valid_o);
      end else if (ack_i && valid_o) begin
        valid_o   <= 1'b0;
        overrun_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte_source.sv
// tb_uart_rx_byte_source: directed and random frames checked against a frame-level reference model.
module tb_uart_rx_byte_source;

  localparam int CPB  = 16;
  localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Clock edges from the start-bit edge to the good-frame load: synchroniser, edge detect,
  // half a bit to the start-bit centre, then the remaining whole bits up to the stop-bit sample.
  localparam int LOAD_EDGE = SYNC + 1 + CPB / 2 + (FRAME_BITS - 1) * CPB;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       rx_i;
  logic       ack_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       overrun_o;
  logic       frame_err_o;
  logic       busy_o;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_o;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] model_data;
  logic       model_valid;
  logic       model_overrun;
  int         exp_fe = 0;
  int         fe_rise = 0;
  int         fe_high = 0;
  logic       fe_prev = 1'b0;
`ifdef UART_RX_PARITY_EN
  int         exp_pe = 0;
  int         pe_rise = 0;
  int         pe_high = 0;
  logic       pe_prev = 1'b0;
`endif

  uart_rx_byte_source #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .rx_i       (rx_i),
    .ack_i      (ack_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .overrun_o  (overrun_o),
    .frame_err_o(frame_err_o),
    .busy_o     (busy_o)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err_o(parity_err_o)
`endif
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts rising edges and high cycles so pulse width can be checked.
  always @(negedge clk) begin
    if (frame_err_o) fe_high++;
    if (frame_err_o && !fe_prev) fe_rise++;
    fe_prev = frame_err_o;
`ifdef UART_RX_PARITY_EN
    if (parity_err_o) pe_high++;
    if (parity_err_o && !pe_prev) pe_rise++;
    pe_prev = parity_err_o;
`endif
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkModel(input string where);
    checkOutput({where, "_data"}, data_o, model_data);
    checkOutput({where, "_valid"}, valid_o, model_valid);
    checkOutput({where, "_overrun"}, overrun_o, model_overrun);
    checkOutput({where, "_busy"}, busy_o, 1'b0);
  endtask

  function automatic logic [10:0] makeFrame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
`ifdef UART_RX_PARITY_EN
    return {stop_ok, (par_ok ? ^d : ~^d), d, 1'b0};
`else
    return {par_ok, stop_ok, d, 1'b0};
`endif
  endfunction

  task automatic driveFrame(input logic [10:0] bits);
    for (int i = 0; i < FRAME_BITS; i++) begin
      rx_i = bits[i];
      tick(CPB);
    end
  endtask

  task automatic doAck(input string where);
    ack_i = 1'b1;
    tick(1);
    ack_i = 1'b0;
    if (model_valid) begin
      model_valid   = 1'b0;
      model_overrun = 1'b0;
    end
    tick(1);
    checkModel(where);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                               input bit ack_at_load, input bit check_timing, input string where);
    logic [10:0] bits;
    bit          good;
    bits = makeFrame(d, stop_ok, par_ok);
    good = stop_ok && par_ok;
    fork
      driveFrame(bits);
      begin
        if (ack_at_load) begin
          tick(LOAD_EDGE - 1);
          ack_i = 1'b1;
          tick(1);
          ack_i = 1'b0;
        end
      end
      begin
        if (check_timing) begin
          tick(LOAD_EDGE - 1);
          checkOutput({where, "_valid_pre_load"}, valid_o, model_valid);
          tick(1);
          checkOutput({where, "_valid_post_load"}, valid_o, good ? 1'b1 : model_valid);
        end
      end
    join
    if (good) begin
      model_overrun = ack_at_load ? 1'b0 : (model_overrun | model_valid);
      model_valid   = 1'b1;
      model_data    = d;
    end else if (ack_at_load && model_valid) begin
      model_valid   = 1'b0;
      model_overrun = 1'b0;
    end
    if (!stop_ok) exp_fe++;
`ifdef UART_RX_PARITY_EN
    if (!par_ok) exp_pe++;
`endif
    if (!stop_ok) begin
      tick(2 * CPB);
      checkOutput({where, "_busy_in_break"}, busy_o, 1'b0);
    end
    rx_i = 1'b1;
    tick(2 * CPB);
    checkModel(where);
  endtask

  initial begin
    int         fe_before;
    logic [7:0] d;
    bit         stop_ok;
    bit         par_ok;
    bit         ack_load;

    rst_i = 1'b1;
    rx_i  = 1'b1;
    ack_i = 1'b0;
    model_data    = 8'h00;
    model_valid   = 1'b0;
    model_overrun = 1'b0;
    tick(3);
    rst_i = 1'b0;
    tick(1);
    checkModel("reset");
    checkOutput("reset_frame_err", frame_err_o, 1'b0);

    applyStimulus(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, "a5");
    checkOutput("a5_data_const", data_o, 32'hA5);
    checkOutput("a5_no_frame_err", fe_rise, 0);

    applyStimulus(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, "3c");
    applyStimulus(8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, "c3");
    checkOutput("c3_overrun_const", overrun_o, 1'b1);
    doAck("ack_after_overrun");

    rx_i = 1'b0;
    tick(4);
    checkOutput("glitch_busy", busy_o, 1'b1);
    tick(1);
    rx_i = 1'b1;
    tick(CPB);
    checkModel("glitch");

    fe_before = fe_rise;
    applyStimulus(8'h55, 1'b0, 1'b1, 1'b0, 1'b0, "bad_stop");
    checkOutput("bad_stop_pulses", fe_rise - fe_before, 1);

    applyStimulus(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, "pre_81");
    applyStimulus(8'h81, 1'b1, 1'b1, 1'b1, 1'b0, "ack_load");
    checkOutput("ack_load_overrun_const", overrun_o, 1'b0);

    fork
      driveFrame(makeFrame(8'hFF, 1'b1, 1'b1));
      begin
        tick(5 * CPB + CPB / 2);
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        model_data    = 8'h00;
        model_valid   = 1'b0;
        model_overrun = 1'b0;
        checkModel("mid_reset");
        checkOutput("mid_reset_frame_err", frame_err_o, 1'b0);
      end
    join
    rx_i = 1'b1;
    tick(2 * CPB);
    checkModel("after_reset");
    applyStimulus(8'h12, 1'b1, 1'b1, 1'b0, 1'b0, "12");

`ifdef UART_RX_PARITY_EN
    doAck("ack_before_parity");
    applyStimulus(8'h12, 1'b1, 1'b0, 1'b0, 1'b0, "bad_parity");
    checkOutput("bad_parity_pulses", pe_rise, exp_pe);
`endif

    for (int i = 0; i < 16; i++) begin
      d        = 8'($urandom);
      stop_ok  = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
      par_ok   = ($urandom_range(0, 5) != 0);
`else
      par_ok   = 1'b1;
`endif
      ack_load = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) doAck("rand_ack");
      applyStimulus(d, stop_ok, par_ok, ack_load, 1'b0, "rand");
    end

    checkOutput("frame_err_count", fe_rise, exp_fe);
    checkOutput("frame_err_width", fe_high, fe_rise);
`ifdef UART_RX_PARITY_EN
    checkOutput("parity_err_count", pe_rise, exp_pe);
    checkOutput("parity_err_width", pe_high, pe_rise);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte_source.md
Name: uart_rx_byte_source

Overview:
- Serial front end for the Wishbone UART RX slave.
- Oversamples the asynchronous RX pin, deserialises 8N1 frames (LSB first) and holds the last good byte on an 8-bit bus that drives the slave's remote data source input.
- Provides valid/overrun/framing status and accepts a single-cycle consume strobe from the bus side.
- Sits between the board RX pin and wishbone_uart_rx_slave.

Parameters:
- CLKS_PER_BIT, 234, system clocks per UART bit (27 MHz / 115200); legal range 4..65535.
- SYNC_STAGES, 2, number of RX input synchroniser flops; legal range 2..3.

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  synchronous reset, active-high
- rx_i  in  1  asynchronous serial line, idle high
- ack_i  in  1  one-cycle consume strobe from the bus side; clears valid_o
- data_o  out  8  last received good byte, held stable until the next good frame
- valid_o  out  1  high while data_o holds an unconsumed byte
- overrun_o  out  1  sticky: a good byte arrived while valid_o=1 and ack_i=0
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low
- busy_o  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - data_o=8'h00, valid_o=0, overrun_o=0, frame_err_o=0, busy_o=0.
  - FSM goes to IDLE, baud counter=0, bit index=0, shift register=0, synchroniser flops=1.
  - Reset mid-frame aborts the frame with no output change other than the reset values.
- rx_i passes through SYNC_STAGES flops; rx_s is the last stage. Falling edge = previous rx_s 1, current rx_s 0.
- Baud counter: 16 bits, counts 0..CLKS_PER_BIT-1, cleared on every state change.
- IDLE:
  - busy_o=0.
  - Falling edge on rx_s -> START, counter=0.
- START:
  - At counter==(CLKS_PER_BIT/2)-1 (integer divide), sample rx_s.
  - 0 -> DATA, counter=0, bit index=0.
  - 1 -> IDLE (glitch rejected; no status change).
- DATA:
  - At counter==CLKS_PER_BIT-1, shift rx_s into bit 7 of the shift register, shifting right (LSB arrives first) and increment the bit index.
  - After the 8th bit -> STOP.
- STOP: at counter==CLKS_PER_BIT-1, sample rx_s.
  - 1 (good frame): on the next edge data_o<=shift register and valid_o<=1; if valid_o was 1 and ack_i was 0 in that cycle, overrun_o<=1. -> IDLE.
  - 0 (framing error): frame_err_o pulses for exactly 1 cycle; data_o, valid_o and overrun_o are unchanged. -> IDLE. A new start is detected only after rx_s returns high and falls again (break holds the FSM in IDLE).
- Latency: valid_o rises 1 clock after the stop-bit sample edge, i.e. about 9.5 bit times after the start edge plus the synchroniser delay.
- ack_i:
  - Clears valid_o and overrun_o on the next edge.
  - ack_i while valid_o=0 has no effect.
  - ack_i in the same cycle as a good-frame load: the load wins, valid_o stays 1, overrun_o is not set.
- data_o is never modified except by a good-frame load or reset.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state sits between DATA and STOP, sampling at counter==CLKS_PER_BIT-1.
  - Adds output parity_err_o (1 bit), a one-cycle pulse when XOR(data bits, parity bit)!=0, issued at the STOP sample together with the frame result.
  - A byte with a parity error is not loaded; valid_o and overrun_o are unchanged.
- Undefined: no PARITY state, no parity_err_o port; frame is 8N1.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, width 3.
  - UART_DATA_BITS=8.
  - Default CLKS_PER_BIT localparam derived from the 27 MHz clock.
- One natural sub-module: uart_rx_sync, the SYNC_STAGES-deep synchroniser plus falling-edge detector. Everything else stays in uart_rx_byte_source.

Test Plan:
- CLKS_PER_BIT=16, send frame 0xA5 8N1 -> valid_o rises ~152 clocks after the start edge; data_o=8'hA5; frame_err_o never pulses; busy_o is low afterwards.
- Send 0x3C with no ack_i, then 0xC3 -> data_o=8'hC3, valid_o=1, overrun_o=1; one ack_i pulse -> valid_o=0 and overrun_o=0 on the next edge.
- Low glitch of 5 clocks on rx_i (CLKS_PER_BIT=16) -> FSM returns to IDLE from START; valid_o, data_o and status are unchanged.
- Send 0x55 with the stop bit driven low -> frame_err_o pulses exactly once; data_o keeps its prior value; valid_o is unchanged; no new frame until rx_i goes high.
- Assert ack_i in the exact cycle of the 0x81 load while valid_o=1 -> data_o=8'h81, valid_o=1, overrun_o=0.
- Assert rst_i at mid data bit 4 of 0xFF -> all outputs take reset values next edge; the next clean 0x12 frame is received correctly. With UART_RX_PARITY_EN defined, 0x12 with a wrong parity bit -> parity_err_o pulses and valid_o stays 0.
